imply_serial_adder: RTL and testbench

- Multi-bit, bit-serial adder/subtractor built from one IMPLY-logic full-adder cell, reused for one bit per clock.
- Successor to the single-bit IMPLY full adder: operand width is parametrised, and it adds a subtract mode, a carry chain held in a register, and a valid/ready handshake on both sides.
- Sits between operand-fetch logic and the result sink in the image-processing datapath. Its step-per-cycle structure models a memristive IMPLY array.

---
 rtl/imply_adder_pkg.sv | 20 ++
 rtl/imply_fa_cell.sv | 35 +++
 rtl/imply_serial_adder.sv | 143 ++++++++++++++
 tb/tb_imply_serial_adder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/imply_adder_pkg.sv
// Shared definitions for the bit-serial IMPLY adder: FSM state encoding,
// the IMPLY primitive and the per-bit step count of the full-adder cell.
package imply_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Material implication p -> q, the only gate the cell may use besides FALSE.
    function automatic logic imply_op(input logic p, input logic q);
        return ~p | q;
    endfunction

    // IMPLY operations the full-adder cell evaluates for one bit
    // (two XORs at 4 each, two ANDs at 3 each, one OR at 2).
    localparam int IMPLY_STEPS_PER_BIT = 16;

endpackage

// File: rtl/imply_fa_cell.sv
// Combinational single-bit full adder built only from IMPLY and FALSE.
// NOT p = p->0, OR(p,q) = (p->0)->q, AND(p,q) = (p->(q->0))->0,
// XOR(p,q) = (p->q) -> ((q->p)->0).
module imply_fa_cell
    import imply_adder_pkg::*;
(
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    localparam logic F = 1'b0;

    logic ab_fwd, ab_bwd, ab_x;
    logic xc_fwd, xc_bwd;
    logic ab_and, xc_and;

    // Half-sum of the operand bits
    assign ab_fwd = imply_op(A, B);
    assign ab_bwd = imply_op(B, A);
    assign ab_x   = imply_op(ab_fwd, imply_op(ab_bwd, F));

    // Full sum: half-sum XOR carry-in
    assign xc_fwd = imply_op(ab_x, Cin);
    assign xc_bwd = imply_op(Cin, ab_x);
    assign Sum    = imply_op(xc_fwd, imply_op(xc_bwd, F));

    // Carry: generate (A&B) OR propagate (Cin & half-sum)
    assign ab_and = imply_op(imply_op(A, imply_op(B, F)), F);
    assign xc_and = imply_op(imply_op(Cin, imply_op(ab_x, F)), F);
    assign Cout   = imply_op(imply_op(ab_and, F), xc_and);

endmodule

// File: rtl/imply_serial_adder.sv
// Bit-serial adder/subtractor: one IMPLY full-adder cell reused for one bit
// per clock, LSB first, with valid/ready handshakes on operands and result.
// Optional macro IMPLY_ADDER_OVF_EN adds the signed-overflow output Ovf.
module imply_serial_adder
    import imply_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
`ifdef IMPLY_ADDER_OVF_EN
    output logic             Ovf,
`endif
    output logic             Cout
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH-1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
`ifdef IMPLY_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic cell_s, cell_c;
    logic accept;
    logic last_bit;

    // The single cell, time-multiplexed across bit positions by idx_q
    imply_fa_cell u_cell (
        .A    (a_q[idx_q]),
        .B    (b_q[idx_q]),
        .Cin  (carry_q),
        .Sum  (cell_s),
        .Cout (cell_c)
    );

    assign accept   = (state_q == IDLE) && in_valid;
    assign last_bit = (idx_q == LAST_IDX);

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef IMPLY_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef IMPLY_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Next-state logic for the IDLE -> RUN -> DONE sequence
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: latch operands on accept, one bit per RUN cycle
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef IMPLY_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    // Subtraction is A + ~B + 1; Cin is ignored in that mode
                    a_d     = A;
                    b_d     = Sub ? ~B : B;
                    carry_d = Sub ? 1'b1 : Cin;
                    idx_d   = '0;
                    sum_d   = '0;
                end
            end
            RUN: begin
                sum_d[idx_q] = cell_s;
                carry_d      = cell_c;
                idx_d        = idx_q + CNT_W'(1);
                if (last_bit) begin
                    cout_d = cell_c;
`ifdef IMPLY_ADDER_OVF_EN
                    // carry_q here is the carry into the MSB
                    ovf_d  = carry_q ^ cell_c;
`endif
                end
            end
            default: ;
        endcase
    end

    // Handshake and result outputs decoded from state and registers
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        Sum       = sum_q;
        Cout      = cout_q;
`ifdef IMPLY_ADDER_OVF_EN
        Ovf       = ovf_q;
`endif
    end

endmodule

// File: tb/tb_imply_serial_adder.sv
// Directed bench for imply_serial_adder (WIDTH=8) and its IMPLY cell.
module tb_imply_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Cin = 1'b0;
    logic         Sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] Sum;
    logic         Cout;
`ifdef IMPLY_ADDER_OVF_EN
    logic         Ovf;
`endif

    logic c_a, c_b, c_ci, c_s, c_co;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    imply_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .Sub       (Sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
`ifdef IMPLY_ADDER_OVF_EN
        .Ovf       (Ovf),
`endif
        .Cout      (Cout)
    );

    imply_fa_cell u_cell_chk (
        .A    (c_a),
        .B    (c_b),
        .Cin  (c_ci),
        .Sum  (c_s),
        .Cout (c_co)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present operands at a falling edge and let the next rising edge accept them
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic sb);
        @(negedge clk);
        A = a; B = b; Cin = ci; Sub = sb; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = ~a; B = ~b; Cin = ~ci; Sub = ~sb;
    endtask

    // Count edges after the accept edge until out_valid, bounded
    task automatic wait_done(input string tag, output int edges);
        edges = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                edges = n;
                break;
            end
        end
        chk({tag, "_lat"}, edges, W);
    endtask

    task automatic release_result(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_idle_ov"}, out_valid, 1'b0);
        chk({tag, "_idle_ir"}, in_ready, 1'b1);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic sb, input logic [W-1:0] es,
                          input logic ec, input logic eo);
        int e;
        issue(a, b, ci, sb);
        chk({tag, "_busy"}, in_ready, 1'b0);
        wait_done(tag, e);
        chk({tag, "_sum"}, Sum, es);
        chk({tag, "_cout"}, Cout, ec);
`ifdef IMPLY_ADDER_OVF_EN
        chk({tag, "_ovf"}, Ovf, eo);
`else
        if (eo === 1'bx) $display("unused ovf expectation");
`endif
        release_result(tag);
    endtask

    initial begin
        logic [1:0] cell_exp [8];
        logic [W-1:0] held_sum;
        logic         held_cout;
        int e;
        cell_exp = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};

        // Exhaustive cell truth table, index = {A,B,Cin}, entry = {Sum,Cout}
        for (int i = 0; i < 8; i++) begin
            {c_a, c_b, c_ci} = 3'(i);
            #1;
            chk($sformatf("cell_%0d", i), {c_s, c_co}, cell_exp[i]);
        end

        // Reset state
        #12;
        chk("rst_ir", in_ready, 1'b1);
        chk("rst_ov", out_valid, 1'b0);
        chk("rst_sum", Sum, 0);
        chk("rst_cout", Cout, 1'b0);
`ifdef IMPLY_ADDER_OVF_EN
        chk("rst_ovf", Ovf, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // 60 + 90 + 1 = 151: no unsigned carry, but signed overflow
        run_op("add", 8'h3C, 8'h5A, 1'b1, 1'b0, 8'h97, 1'b0, 1'b1);
        run_op("wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("sub", 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
        run_op("ssub", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Backpressure: result held while out_ready=0, in_valid ignored
        issue(8'h21, 8'h12, 1'b0, 1'b0);
        wait_done("bp", e);
        held_sum = Sum;
        held_cout = Cout;
        chk("bp_sum", held_sum, 8'h33);
        @(negedge clk);
        A = 8'h05; B = 8'h03; Cin = 1'b0; Sub = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_ov_%0d", k), out_valid, 1'b1);
            chk($sformatf("bp_ir_%0d", k), in_ready, 1'b0);
            chk($sformatf("bp_hold_%0d", k), {Cout, Sum}, {held_cout, held_sum});
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_rel_ov", out_valid, 1'b0);
        chk("bp_rel_ir", in_ready, 1'b1);
        // in_valid still high: accepted at this next edge
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("b2b_busy", in_ready, 1'b0);
        wait_done("b2b", e);
        chk("b2b_sum", Sum, 8'h08);
        chk("b2b_cout", Cout, 1'b0);
        release_result("b2b");

        // Reset during RUN after bits 0..2 are written (idx at 3)
        issue(8'hFF, 8'h00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        chk("mid_partial", Sum, 8'h07);
        rst_n = 1'b0;
        #1;
        chk("mid_ir", in_ready, 1'b1);
        chk("mid_ov", out_valid, 1'b0);
        chk("mid_sum", Sum, 0);
        chk("mid_cout", Cout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        // No result must appear for the aborted operation
        repeat (12) @(posedge clk);
        #1;
        chk("mid_noresult", out_valid, 1'b0);
        run_op("post", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
